// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the binary-to-BCD converter and BCD adder path.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;
    localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH)
            q = d + BCD_ADJ_ADD;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-packed-BCD converter (shift-and-add-3), one bit per cycle.
// Optional sticky overflow output when BIN2BCD_OVF_EN is defined.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef BIN2BCD_OVF_EN
    output logic                  ovf,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(BIN_W + 1);

    b2b_state_t state, state_nxt;

    logic [BIN_W-1:0]    bin_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CW-1:0]       cnt;
`ifdef BIN2BCD_OVF_EN
    logic                ovf_reg;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_reg[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = SHIFT;
            SHIFT: if (cnt == CW'(1)) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, adjust-then-shift while in SHIFT, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            cnt     <= '0;
`ifdef BIN2BCD_OVF_EN
            ovf_reg <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                bin_reg <= bin_in;
                bcd_reg <= '0;
                cnt     <= CW'(BIN_W);
`ifdef BIN2BCD_OVF_EN
                ovf_reg <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                cnt <= cnt - CW'(1);
`ifdef BIN2BCD_OVF_EN
                ovf_reg <= ovf_reg | bcd_adj[4*DIGITS-1];
`endif
            end
        end
    end

    assign bcd_out = bcd_reg;
`ifdef BIN2BCD_OVF_EN
    assign ovf = ovf_reg;
`endif

endmodule
